configs_loader: RTL and testbench

Clocked, parametrised successor to the level-sensitive config latch bank: it accepts a stream of configuration words over a valid/ready handshake into a shadow store, then updates the live configuration image atomically in one commit cycle. It sits between the tile's configuration shift/scan controller and the LUT/routing fabric. Because of the double buffering, the fabric never sees a partially written image. A registered readback port exposes the shadow store to the controller.

---
 rtl/configs_pkg.sv | 21 ++
 rtl/configs_word_bank.sv | 48 ++++
 rtl/configs_loader.sv | 119 +++++++++++
 tb/tb_configs_loader.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/configs_pkg.sv
// Shared definitions for the configuration loader slice.
//   state_t  : loader FSM states
//   addr_w   : word-index width for a given image size
//   word_lsb : bit offset of word k in a flattened image (used by fabric consumers)
package configs_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int word_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/configs_word_bank.sv
// Shadow store for one configuration image.
//   clk, reset           : clock, synchronous active-high reset (clears all words)
//   wr_en/wr_addr/wr_data: single write port
//   rd_addr/rd_data      : registered readback, out-of-range addresses return 0
//   words                : all shadow words, flattened, word k at [k*DATA_W +: DATA_W]
module configs_word_bank
  import configs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 18,
  parameter int ADDR_W    = addr_w(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [DATA_W*NUM_WORDS-1:0] words
);

  logic [DATA_W-1:0] mem [NUM_WORDS];
  logic              rd_in_range;

  // Extra bit keeps the compare correct when NUM_WORDS is a power of two.
  assign rd_in_range = {1'b0, rd_addr} < (ADDR_W+1)'(NUM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      // Read sees the pre-write value on a same-address collision.
      rd_data <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : gen_words
    assign words[word_lsb(g, DATA_W) +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/configs_loader.sv
// Double-buffered configuration loader.
//   clk, reset      : clock, synchronous active-high reset
//   io_start        : begin/restart a load session
//   io_d_in/valid   : configuration word stream; io_d_ready from registered state
//   io_rd_addr/data : registered shadow readback (1-cycle latency)
//   io_busy         : high in LOAD and COMMIT
//   io_done         : one-cycle pulse while the new live image is first visible
//   io_err          : sticky protocol error (stray data, restart mid-session)
//   io_configs_out  : live image, word k at [k*DATA_W +: DATA_W]
module configs_loader
  import configs_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NUM_WORDS = 18,
  localparam int ADDR_W    = addr_w(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_start,
  input  logic [DATA_W-1:0]           io_d_in,
  input  logic                        io_d_valid,
  output logic                        io_d_ready,
  input  logic [ADDR_W-1:0]           io_rd_addr,
  output logic [DATA_W-1:0]           io_rd_data,
  output logic                        io_busy,
  output logic                        io_done,
  output logic                        io_err,
  output logic [DATA_W*NUM_WORDS-1:0] io_configs_out
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);

  state_t                      state;
  logic [ADDR_W-1:0]           cnt;
  logic                        err;
  logic [DATA_W*NUM_WORDS-1:0] live;
  logic [DATA_W*NUM_WORDS-1:0] shadow_words;
  logic                        accept;
  logic                        last_beat;

  // A restart discards any beat presented in the same cycle.
  assign accept    = (state == LOAD) && io_d_valid && !io_start;
  assign last_beat = accept && (cnt == LAST);

  configs_word_bank #(
    .DATA_W   (DATA_W),
    .NUM_WORDS(NUM_WORDS),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (accept),
    .wr_addr(cnt),
    .wr_data(io_d_in),
    .rd_addr(io_rd_addr),
    .rd_data(io_rd_data),
    .words  (shadow_words)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      live  <= '0;
    end else begin
      // The live register is loaded on the last-beat edge, with that beat
      // bypassed in from the input, so the new image and io_done (decoded
      // from COMMIT) appear in the same cycle.
      if (last_beat) begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          live[i*DATA_W +: DATA_W] <= (ADDR_W'(i) == cnt) ? io_d_in
                                                          : shadow_words[i*DATA_W +: DATA_W];
        end
      end

      case (state)
        IDLE: begin
          if (io_start) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
          end else if (io_d_valid) begin
            err <= 1'b1;
          end
        end
        LOAD: begin
          if (io_start) begin
            cnt <= '0;
            err <= 1'b1;
          end else if (accept) begin
            if (cnt == LAST) begin
              state <= COMMIT;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (io_start) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_d_ready     = (state == LOAD);
  assign io_busy        = (state != IDLE);
  assign io_done        = (state == COMMIT);
  assign io_err         = err;
  assign io_configs_out = live;

endmodule

// File: tb/tb_configs_loader.sv
module tb_configs_loader;

  localparam int DW = 32;
  localparam int NW = 18;
  localparam int AW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             io_start;
  logic [DW-1:0]    io_d_in;
  logic             io_d_valid;
  logic             io_d_ready;
  logic [AW-1:0]    io_rd_addr;
  logic [DW-1:0]    io_rd_data;
  logic             io_busy;
  logic             io_done;
  logic             io_err;
  logic [DW*NW-1:0] io_configs_out;

  always #5 clk = ~clk;

  configs_loader #(.DATA_W(DW), .NUM_WORDS(NW)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_start      (io_start),
    .io_d_in       (io_d_in),
    .io_d_valid    (io_d_valid),
    .io_d_ready    (io_d_ready),
    .io_rd_addr    (io_rd_addr),
    .io_rd_data    (io_rd_data),
    .io_busy       (io_busy),
    .io_done       (io_done),
    .io_err        (io_err),
    .io_configs_out(io_configs_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: shadow store and live image as plain word arrays.
  logic [DW-1:0] shadow_m [NW];
  logic [DW-1:0] live_m   [NW];
  logic [DW-1:0] tx       [NW];

  function automatic logic [DW*NW-1:0] live_image();
    logic [DW*NW-1:0] v;
    for (int i = 0; i < NW; i++) v[i*DW +: DW] = live_m[i];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int i = 0; i < NW; i++) begin
      shadow_m[i] = '0;
      live_m[i]   = '0;
    end
  endtask

  task automatic random_tx();
    for (int i = 0; i < NW; i++) tx[i] = $urandom;
  endtask

  task automatic start_session();
    io_start = 1'b1;
    step();
    io_start = 1'b0;
  endtask

  // Drives tx[first..last_excl-1] as beats with random gaps. Counts cycles in
  // which the image or io_done changed before the final beat was taken.
  task automatic send_words(input int first, input int last_excl, input int gap_pct,
                            output int cycles, output int premature, output int timeout);
    int   k;
    logic rdy;
    k = first;
    cycles = 0;
    premature = 0;
    timeout = 0;
    while (k < last_excl && cycles < 400) begin
      io_d_in    = tx[k];
      io_d_valid = ($urandom_range(99) >= gap_pct);
      rdy        = io_d_ready;
      step();
      cycles++;
      if (io_d_valid && rdy) begin
        shadow_m[k] = tx[k];
        k++;
      end
      if (k < last_excl && io_done) premature++;
      if (k < last_excl && io_configs_out !== live_image()) premature++;
    end
    io_d_valid = 1'b0;
    if (k < last_excl) timeout = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_models();
    checks++;
    if ({io_d_ready, io_busy, io_done, io_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/done/err=%b want 0000",
               {io_d_ready, io_busy, io_done, io_err});
    end
    checks++;
    if (io_configs_out !== '0 || io_rd_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got image=%h rd=%h want all zero", io_configs_out, io_rd_data);
    end
  endtask

  task automatic test_nominal();
    int cyc, prem, to;
    start_session();
    checks++;
    if (io_d_ready !== 1'b1 || io_err !== 1'b0) begin
      errors++;
      $display("FAIL nominal_start: got rdy=%b err=%b want 1 0", io_d_ready, io_err);
    end
    for (int k = 0; k < NW; k++) tx[k] = 32'(k) * 32'h01010101;
    send_words(0, NW, 0, cyc, prem, to);
    checks++;
    if (prem != 0 || to != 0 || cyc != NW) begin
      errors++;
      $display("FAIL nominal_timing: got premature=%0d timeout=%0d cycles=%0d want 0 0 %0d",
               prem, to, cyc, NW);
    end
    live_m = shadow_m;
    checks++;
    if (io_done !== 1'b1 || io_d_ready !== 1'b0 || io_busy !== 1'b1) begin
      errors++;
      $display("FAIL nominal_commit: got done/rdy/busy=%b%b%b want 101", io_done, io_d_ready, io_busy);
    end
    checks++;
    if (io_configs_out[575:544] !== 32'h11111111) begin
      errors++;
      $display("FAIL nominal_word17: got %h want 11111111", io_configs_out[575:544]);
    end
    checks++;
    if (io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL nominal_image: got %h want %h", io_configs_out, live_image());
    end
    step();
    checks++;
    if (io_done !== 1'b0 || io_busy !== 1'b0 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL nominal_after: got done=%b busy=%b want 0 0, image held", io_done, io_busy);
    end
  endtask

  task automatic test_readback();
    int            cyc, prem, to;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    io_rd_addr = 5'd3;
    step();
    checks++;
    if (io_rd_data !== 32'h03030303) begin
      errors++;
      $display("FAIL readback_3: got %h want 03030303", io_rd_data);
    end
    io_rd_addr = 5'd31;
    step();
    checks++;
    if (io_rd_data !== '0) begin
      errors++;
      $display("FAIL readback_31: got %h want 0", io_rd_data);
    end
    for (int r = 0; r < 8; r++) begin
      a = 5'($urandom_range(31));
      exp = (a < NW) ? shadow_m[a] : '0;
      io_rd_addr = a;
      step();
      checks++;
      if (io_rd_data !== exp) begin
        errors++;
        $display("FAIL readback_rand[%0d]: got %h want %h", a, io_rd_data, exp);
      end
    end
    // Same-edge write and read of word 0.
    start_session();
    random_tx();
    io_rd_addr = 5'd0;
    io_d_in    = tx[0];
    io_d_valid = 1'b1;
    exp        = shadow_m[0];
    step();
    io_d_valid  = 1'b0;
    shadow_m[0] = tx[0];
    checks++;
    if (io_rd_data !== exp) begin
      errors++;
      $display("FAIL readback_collide_old: got %h want %h", io_rd_data, exp);
    end
    step();
    checks++;
    if (io_rd_data !== tx[0]) begin
      errors++;
      $display("FAIL readback_collide_new: got %h want %h", io_rd_data, tx[0]);
    end
    send_words(1, NW, 0, cyc, prem, to);
    live_m = shadow_m;
    checks++;
    if (prem != 0 || to != 0 || io_done !== 1'b1 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL readback_commit: got premature=%0d timeout=%0d done=%b want 0 0 1",
               prem, to, io_done);
    end
    step();
  endtask

  task automatic test_backpressure();
    int cyc, prem, to;
    for (int s = 0; s < 3; s++) begin
      start_session();
      random_tx();
      send_words(0, NW, 45, cyc, prem, to);
      checks++;
      if (prem != 0 || to != 0) begin
        errors++;
        $display("FAIL gaps_early[%0d]: got premature=%0d timeout=%0d want 0 0", s, prem, to);
      end
      live_m = shadow_m;
      checks++;
      if (io_done !== 1'b1 || io_configs_out !== live_image()) begin
        errors++;
        $display("FAIL gaps_image[%0d]: got done=%b image=%h want 1 %h",
                 s, io_done, io_configs_out, live_image());
      end
      step();
    end
  endtask

  task automatic test_restart();
    int cyc, prem, to;
    start_session();
    random_tx();
    send_words(0, 5, 20, cyc, prem, to);
    io_rd_addr = 5'd5;
    io_start   = 1'b1;
    io_d_valid = 1'b1;
    io_d_in    = 32'hDEADBEEF;
    step();
    io_start   = 1'b0;
    io_d_valid = 1'b0;
    checks++;
    if (io_err !== 1'b1 || io_d_ready !== 1'b1 || io_done !== 1'b0 || prem != 0 || to != 0) begin
      errors++;
      $display("FAIL restart_flags: got err=%b rdy=%b done=%b prem=%0d want 1 1 0 0",
               io_err, io_d_ready, io_done, prem);
    end
    step();
    checks++;
    if (io_rd_data !== shadow_m[5] || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL restart_discard: got rd5=%h want %h, image held", io_rd_data, shadow_m[5]);
    end
    random_tx();
    send_words(0, NW - 1, 0, cyc, prem, to);
    checks++;
    if (prem != 0 || to != 0 || io_done !== 1'b0 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL restart_17: got prem=%0d to=%0d done=%b want 0 0 0", prem, to, io_done);
    end
    send_words(NW - 1, NW, 0, cyc, prem, to);
    live_m = shadow_m;
    checks++;
    if (io_done !== 1'b1 || io_configs_out !== live_image() || io_err !== 1'b1) begin
      errors++;
      $display("FAIL restart_commit: got done=%b err=%b want 1 1, image %h want %h",
               io_done, io_err, io_configs_out, live_image());
    end
    // Restart while in COMMIT: commit stands, new session opens.
    start_session();
    checks++;
    if (io_d_ready !== 1'b1 || io_done !== 1'b0 || io_err !== 1'b1 ||
        io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL restart_in_commit: got rdy=%b done=%b err=%b want 1 0 1",
               io_d_ready, io_done, io_err);
    end
    random_tx();
    send_words(0, NW, 30, cyc, prem, to);
    live_m = shadow_m;
    checks++;
    if (prem != 0 || to != 0 || io_done !== 1'b1 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL restart_reload: got prem=%0d to=%0d done=%b want 0 0 1", prem, to, io_done);
    end
    step();
  endtask

  task automatic test_stray();
    int cyc, prem, to;
    start_session();
    checks++;
    if (io_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_clear_prior: got err=%b want 0", io_err);
    end
    random_tx();
    send_words(0, NW, 10, cyc, prem, to);
    live_m = shadow_m;
    step();
    io_rd_addr = 5'd17;
    io_d_valid = 1'b1;
    io_d_in    = ~shadow_m[17];
    checks++;
    if (io_d_ready !== 1'b0 || io_busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ready: got rdy=%b busy=%b want 0 0", io_d_ready, io_busy);
    end
    step();
    io_d_valid = 1'b0;
    checks++;
    if (io_err !== 1'b1 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL stray_err: got err=%b want 1, image %h want %h",
               io_err, io_configs_out, live_image());
    end
    step();
    checks++;
    if (io_rd_data !== shadow_m[17] || io_err !== 1'b1) begin
      errors++;
      $display("FAIL stray_shadow: got rd17=%h err=%b want %h 1", io_rd_data, io_err, shadow_m[17]);
    end
    start_session();
    checks++;
    if (io_err !== 1'b0) begin
      errors++;
      $display("FAIL stray_start_clears: got err=%b want 0", io_err);
    end
    random_tx();
    send_words(0, NW, 0, cyc, prem, to);
    live_m = shadow_m;
    checks++;
    if (prem != 0 || to != 0 || io_done !== 1'b1 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL stray_reload: got prem=%0d to=%0d done=%b want 0 0 1", prem, to, io_done);
    end
    step();
  endtask

  task automatic test_reset_midload();
    int cyc, prem, to;
    start_session();
    random_tx();
    send_words(0, 10, 25, cyc, prem, to);
    io_rd_addr = 5'd2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_models();
    checks++;
    if ({io_d_ready, io_busy, io_done, io_err} !== 4'b0000 ||
        io_configs_out !== '0 || io_rd_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy/busy/done/err=%b rd=%h image=%h want all zero",
               {io_d_ready, io_busy, io_done, io_err}, io_rd_data, io_configs_out);
    end
    step();
    checks++;
    if (io_busy !== 1'b0 || io_rd_data !== '0) begin
      errors++;
      $display("FAIL midreset_idle: got busy=%b rd2=%h want 0 0", io_busy, io_rd_data);
    end
    start_session();
    random_tx();
    send_words(0, NW, 20, cyc, prem, to);
    live_m = shadow_m;
    checks++;
    if (prem != 0 || to != 0 || io_done !== 1'b1 || io_configs_out !== live_image()) begin
      errors++;
      $display("FAIL midreset_reload: got prem=%0d to=%0d done=%b want 0 0 1", prem, to, io_done);
    end
    step();
  endtask

  initial begin
    reset      = 1'b1;
    io_start   = 1'b0;
    io_d_in    = '0;
    io_d_valid = 1'b0;
    io_rd_addr = '0;
    test_reset();
    test_nominal();
    test_readback();
    test_backpressure();
    test_restart();
    test_stray();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
